// File: rtl/pipeline_rr_scheduler.sv
// Round-robin front end that shares one external 3-stage arithmetic pipeline between NREQ requesters.
// A valid/ID tag shift register follows each issue so that every result comes back with the ID of its requester.
module pipeline_rr_scheduler #(
  parameter int unsigned N    = 10,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned LAT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*N-1:0] req_c,
  input  logic [NREQ*N-1:0] req_d,
  output logic [N-1:0]      pipe_a,
  output logic [N-1:0]      pipe_b,
  output logic [N-1:0]      pipe_c,
  output logic [N-1:0]      pipe_d,
  input  logic [N-1:0]      pipe_f,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_f,
  output logic              busy,
  output logic [15:0]       issue_cnt
);

  localparam int unsigned CNTW = 16;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           issue;
  logic [LAT-1:0] tag_v;
  logic [IDW-1:0] tag_id [LAT];

  // Search from ptr upward and grant the first valid requester; nothing is granted while held in reset.
  always_comb begin
    req_ready = '0;
    win       = '0;
    issue     = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      if (!issue && en && rst_n && req_valid[IDW'((32'(ptr) + off) % NREQ)]) begin
        issue = 1'b1;
        win   = IDW'((32'(ptr) + off) % NREQ);
      end
    end
    if (issue) req_ready[win] = 1'b1;
  end

  // Operand mux; all-zero when no grant is made.
  always_comb begin
    pipe_a = '0;
    pipe_b = '0;
    pipe_c = '0;
    pipe_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        pipe_a = req_a[i*N +: N];
        pipe_b = req_b[i*N +: N];
        pipe_c = req_c[i*N +: N];
        pipe_d = req_d[i*N +: N];
      end
    end
  end

  // Pointer, issue counter, and the tag pipe. The tag pipe shifts on every edge, even when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      issue_cnt <= '0;
      tag_v     <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_id[i] <= '0;
    end else begin
      if (issue) begin
        ptr       <= IDW'((32'(win) + 32'd1) % NREQ);
        issue_cnt <= issue_cnt + CNTW'(1);
      end
      tag_v[0]  <= issue;
      tag_id[0] <= win;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rsp_valid = tag_v[LAT-1];
  assign rsp_id    = tag_id[LAT-1];
  assign rsp_f     = pipe_f;
  assign busy      = issue | (|tag_v);

endmodule
